// File: rtl/wb_mgr_pkg.sv
// Shared types and constants for the queued Wishbone manager.
// Holds the FSM state encoding, the request record layout and the error data pattern.
// No logic; imported by the manager top level.
package wb_mgr_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADR_W  = 32;
  // Widest data bus the error pattern helper can fill.
  localparam int MAX_DATA_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Request record at the default widths; the top level declares the same
  // layout sized from its own parameters.
  typedef struct packed {
    logic                    we;
    logic [DEF_ADR_W-1:0]    adr;
    logic [DEF_DATA_W-1:0]   dat;
    logic [DEF_DATA_W/8-1:0] sel;
  } req_t;

  // 16'hBAD1 repeated across the low 'width' bits; callers slice what they need.
  function automatic logic [MAX_DATA_W-1:0] bad_pattern(input int width);
    logic [MAX_DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_DATA_W / 16; i++) begin
      if (i * 16 < width) p[i*16 +: 16] = 16'hBAD1;
    end
    return p;
  endfunction

endpackage

// File: rtl/wb_queued_manager_fifo.sv
// Request queue: DEPTH-entry synchronous FIFO with registered occupancy count.
// Latency: pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module wb_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_dat,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); push+pop keeps count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/wb_queued_manager.sv
// Wishbone classic manager with a request queue, ERR_I handling and a strobe watchdog.
// Latency: push into idle empty queue -> STB_O next cycle; termination -> RSP_VALID_O next cycle.
// Backpressure: REQ_READY_O = queue not full (registered count); requests held by CPU while full.
module wb_queued_manager
  import wb_mgr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADR_W   = 32,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                REQ_VALID_I,
  output logic                REQ_READY_O,
  input  logic                REQ_WE_I,
  input  logic [ADR_W-1:0]    REQ_ADR_I,
  input  logic [DATA_W-1:0]   REQ_DAT_I,
  input  logic [DATA_W/8-1:0] REQ_SEL_I,
  output logic                RSP_VALID_O,
  output logic [DATA_W-1:0]   RSP_DAT_O,
  output logic                RSP_ERR_O,
  output logic                BUSY_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I,
  output logic [ADR_W-1:0]    ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic                WE_O,
  output logic                STB_O,
  output logic                CYC_O
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [MAX_DATA_W-1:0] BAD_FULL = bad_pattern(DATA_W);
  localparam logic [DATA_W-1:0]     BAD      = BAD_FULL[DATA_W-1:0];

  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } req_q_t;

  state_t            state, state_nxt;
  req_q_t            push_req, head_req;
  logic              push, pop, term, bad_end, tmo_hit;
  logic              q_full, q_empty;
  logic [CNT_W-1:0]  q_count, cnt_nxt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              we_q, stb_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rsp_vld_q, rsp_err_q, busy_q;
  logic [DATA_W-1:0] rsp_dat_q;

  assign push_req = '{we: REQ_WE_I, adr: REQ_ADR_I, dat: REQ_DAT_I, sel: REQ_SEL_I};
  assign push     = REQ_VALID_I && !q_full;

  wb_req_fifo #(
    .W     ($bits(req_q_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .pop      (pop),
    .push_dat (push_req),
    .pop_dat  (head_req),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // tmo_cnt counts BUS cycles already completed, so the cycle in which it
  // reads TIMEOUT-1 is the TIMEOUT-th strobe cycle and the last one allowed.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  // Error data unless a clean ACK ends the cycle (ERR beats ACK, ACK beats timeout).
  assign bad_end = ERR_I || !ACK_I;
  assign cnt_nxt = q_count + CNT_W'(push) - CNT_W'(pop);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: issue the queue head from IDLE, finish on ACK/ERR/watchdog.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    term      = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop       = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (ACK_I || ERR_I || tmo_hit) begin
          term      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are loaded at issue, held through the cycle, cleared at the end.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      we_q  <= 1'b0;
      stb_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (pop) begin
      we_q  <= head_req.we;
      stb_q <= 1'b1;
      adr_q <= head_req.adr;
      dat_q <= head_req.we ? head_req.dat : '0;
      sel_q <= head_req.sel;
    end else if (term) begin
      we_q  <= 1'b0;
      stb_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end
  end

  // Watchdog: restart at issue, advance on every non-final BUS cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       tmo_cnt <= '0;
    else if (pop)                    tmo_cnt <= '0;
    else if (state == BUS && !term)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // One-cycle response pulse; data persists until the next response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      rsp_vld_q <= term;
      rsp_err_q <= term && bad_end;
      if (term) rsp_dat_q <= bad_end ? BAD : (we_q ? '0 : DAT_I);
    end
  end

  // Busy mirrors the post-edge queue occupancy and FSM state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) busy_q <= 1'b0;
    else       busy_q <= (cnt_nxt != '0) || (state_nxt == BUS);
  end

  assign REQ_READY_O = !q_full;
  assign RSP_VALID_O = rsp_vld_q;
  assign RSP_ERR_O   = rsp_err_q;
  assign RSP_DAT_O   = rsp_dat_q;
  assign BUSY_O      = busy_q;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign SEL_O       = sel_q;
  assign WE_O        = we_q;
  assign STB_O       = stb_q;
  assign CYC_O       = stb_q;

endmodule

// File: tb/tb_wb_queued_manager.sv
module tb_wb_queued_manager;

  localparam int QD  = 4;
  localparam int TMO = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } mreq_t;

  typedef struct {
    int          kind;   // 0 ack, 1 err, 2 ack+err, 3 silent
    int          lat;    // strobe cycle in which the slave answers
    logic [31:0] dat;
  } plan_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        ack_i, err_i;
  logic [31:0] dat_i;
  logic        req_ready, rsp_valid, rsp_err, busy, we_o, stb_o, cyc_o;
  logic [31:0] rsp_dat, adr_o, dat_o;
  logic [3:0]  sel_o;

  logic        x_valid = 1'b0, x_ack = 1'b0, x_err = 1'b0;
  logic [63:0] x_dat_i = '0, x_dat_in = 64'h1111_2222_3333_4444;
  logic [7:0]  x_sel_i = '0;
  logic [31:0] x_adr_i = '0;
  logic        x_ready, x_rsp_vld, x_rsp_err, x_busy, x_we, x_stb, x_cyc;
  logic [63:0] x_rsp_dat, x_dato;
  logic [31:0] x_adr;
  logic [7:0]  x_sel;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_queued_manager #(.DATA_W(32), .ADR_W(32), .QDEPTH(QD), .TIMEOUT(TMO)) dut (
    .CLK(clk), .nRST(nrst),
    .REQ_VALID_I(req_valid), .REQ_READY_O(req_ready), .REQ_WE_I(req_we),
    .REQ_ADR_I(req_adr), .REQ_DAT_I(req_dat), .REQ_SEL_I(req_sel),
    .RSP_VALID_O(rsp_valid), .RSP_DAT_O(rsp_dat), .RSP_ERR_O(rsp_err), .BUSY_O(busy),
    .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i),
    .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o)
  );

  wb_queued_manager #(.DATA_W(64), .ADR_W(32), .QDEPTH(2), .TIMEOUT(4)) dut64 (
    .CLK(clk), .nRST(nrst),
    .REQ_VALID_I(x_valid), .REQ_READY_O(x_ready), .REQ_WE_I(1'b0),
    .REQ_ADR_I(x_adr_i), .REQ_DAT_I(x_dat_i), .REQ_SEL_I(x_sel_i),
    .RSP_VALID_O(x_rsp_vld), .RSP_DAT_O(x_rsp_dat), .RSP_ERR_O(x_rsp_err), .BUSY_O(x_busy),
    .DAT_I(x_dat_in), .ACK_I(x_ack), .ERR_I(x_err),
    .ADR_O(x_adr), .DAT_O(x_dato), .SEL_O(x_sel), .WE_O(x_we), .STB_O(x_stb), .CYC_O(x_cyc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: requests as a queue, bus as one slot ----
  mreq_t       m_pend[$];
  mreq_t       m_cur;
  bit          m_active = 0;
  int          m_cyc = 0;
  bit          m_rsp_vld = 0, m_rsp_err = 0;
  logic [31:0] m_rsp_dat = '0;

  always @(posedge clk or negedge nrst) begin : model
    bit    acc;
    mreq_t r;
    if (!nrst) begin
      m_pend.delete();
      m_active  = 0;
      m_cyc     = 0;
      m_rsp_vld = 0;
      m_rsp_err = 0;
      m_rsp_dat = '0;
    end else begin
      acc = req_valid && (m_pend.size() < QD);
      m_rsp_vld = 0;
      m_rsp_err = 0;
      if (m_active) begin
        m_cyc++;
        if (err_i || ack_i || m_cyc == TMO) begin
          m_active  = 0;
          m_rsp_vld = 1;
          if (err_i || !ack_i) begin
            m_rsp_err = 1;
            m_rsp_dat = 32'hBAD1_BAD1;
          end else begin
            m_rsp_dat = m_cur.we ? 32'h0 : dat_i;
          end
        end
      end else if (m_pend.size() != 0) begin
        m_cur    = m_pend.pop_front();
        m_active = 1;
        m_cyc    = 0;
      end
      if (acc) begin
        r.we = req_we; r.adr = req_adr; r.dat = req_dat; r.sel = req_sel;
        m_pend.push_back(r);
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ready", req_ready, m_pend.size() < QD);
    chk("busy",  busy, (m_pend.size() != 0) || m_active);
    chk("stb",   stb_o, m_active);
    chk("cyc",   cyc_o, m_active);
    chk("we",    we_o,  m_active ? m_cur.we : 1'b0);
    chk("adr",   adr_o, m_active ? m_cur.adr : 32'h0);
    chk("dato",  dat_o, (m_active && m_cur.we) ? m_cur.dat : 32'h0);
    chk("sel",   sel_o, m_active ? m_cur.sel : 4'h0);
    chk("rsp_vld", rsp_valid, m_rsp_vld);
    chk("rsp_err", rsp_err, m_rsp_err);
    chk("rsp_dat", rsp_dat, m_rsp_dat);
  end

  // ---------------- slave behaviour, scripted per transaction ---------------
  plan_t s_plan[$];
  plan_t s_cur;
  int    s_run = 0;
  bit    spur = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      ack_i = 0; err_i = 0; dat_i = 32'h5555_5555; s_run = 0;
    end else if (stb_o) begin
      if (s_run == 0) begin
        if (s_plan.size() != 0) s_cur = s_plan.pop_front();
        else s_cur = '{kind: 0, lat: 1, dat: 32'h0};
      end
      s_run++;
      ack_i = 0; err_i = 0; dat_i = 32'h5555_5555;
      if (s_run == s_cur.lat) begin
        case (s_cur.kind)
          0: begin ack_i = 1; dat_i = s_cur.dat; end
          1: err_i = 1;
          2: begin ack_i = 1; err_i = 1; dat_i = s_cur.dat; end
          default: ;
        endcase
      end
    end else begin
      s_run = 0; ack_i = spur; err_i = 0; dat_i = 32'h5555_5555;
    end
  end

  // ---------------- observation logs for literal checks ----------------------
  rsp_t rsp_log[$];
  int   rsp_cyc[$];
  int   stb_len_log[$];
  int   run_len = 0;
  int   rise_cyc = 0;

  always @(negedge clk) begin
    rsp_t r;
    if (stb_o) begin
      if (run_len == 0) rise_cyc = cyc;
      run_len++;
    end else if (run_len != 0) begin
      stb_len_log.push_back(run_len);
      run_len = 0;
    end
    if (rsp_valid) begin
      r.err = rsp_err; r.dat = rsp_dat; r.cyc = cyc_o;
      rsp_log.push_back(r);
      rsp_cyc.push_back(cyc);
    end
  end

  function automatic rsp_t rsp_at(input int i);
    rsp_t d;
    d = '{err: 1'bx, dat: 32'hxxxx_xxxx, cyc: 1'bx};
    if (i < rsp_log.size()) d = rsp_log[i];
    return d;
  endfunction

  function automatic int stb_len_at(input int i);
    return (i < stb_len_log.size()) ? stb_len_log[i] : -1;
  endfunction

  task automatic clear_logs();
    rsp_log.delete(); rsp_cyc.delete(); stb_len_log.delete();
  endtask

  // Present a request at the current negedge and hold it until accepted.
  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int acc);
    int n = 0;
    req_valid = 1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("push_wait_bound", 0, 1);
    @(negedge clk);
    acc = cyc;
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k = 0;
    while (rsp_log.size() < n && k < 300) begin @(negedge clk); k++; end
    chk(name, rsp_log.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, acc6, n;
    nrst = 1;
    #1 nrst = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_stb", stb_o, 0);
    chk("reset_rsp", rsp_valid, 0);
    nrst = 1;

    // Stray ACK while idle must not produce anything.
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    @(negedge clk);
    chk("spurious_ack_rsp", rsp_log.size(), 0);

    // Single read, slave answers in third strobe cycle.
    clear_logs();
    s_plan.push_back('{kind: 0, lat: 3, dat: 32'hDEAD_BEEF});
    push(1'b0, 32'h3000_0004, 32'h0, 4'hF, acc);
    wait_rsp(1, "read_rsp_count");
    chk("read_latency", rise_cyc - acc, 1);
    chk("read_dat", rsp_at(0).dat, 32'hDEAD_BEEF);
    chk("read_err", rsp_at(0).err, 0);
    chk("read_stb_len", stb_len_at(0), 3);
    repeat (2) @(negedge clk);

    // Queue fill: one write on the bus plus four queued makes the queue full.
    clear_logs();
    s_plan.push_back('{kind: 0, lat: 5, dat: 32'h0});
    for (int i = 0; i < 5; i++) s_plan.push_back('{kind: 0, lat: 2, dat: 32'h0});
    for (int i = 0; i < 5; i++)
      push(1'b1, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'h3, acc);
    chk("fill_ready_low", req_ready, 0);
    push(1'b1, 32'h1000_0014, 32'hA000_0005, 4'hC, acc6);
    chk("fill_sixth_after_first_rsp", (rsp_cyc.size() > 0) && (acc6 > rsp_cyc[0]), 1);
    wait_rsp(6, "fill_rsp_count");
    chk("fill_last_dat", rsp_at(5).dat, 32'h0);
    chk("fill_last_err", rsp_at(5).err, 0);
    repeat (2) @(negedge clk);

    // ERR and ACK together: error wins.
    clear_logs();
    s_plan.push_back('{kind: 2, lat: 2, dat: 32'h0BAD_0BAD});
    push(1'b0, 32'h3000_0008, 32'h0, 4'hF, acc);
    wait_rsp(1, "err_rsp_count");
    chk("err_flag", rsp_at(0).err, 1);
    chk("err_dat", rsp_at(0).dat, 32'hBAD1_BAD1);
    chk("err_cyc_low", rsp_at(0).cyc, 0);
    repeat (2) @(negedge clk);

    // Silent slave: watchdog after TMO strobe cycles, next request proceeds.
    clear_logs();
    s_plan.push_back('{kind: 3, lat: 0, dat: 32'h0});
    s_plan.push_back('{kind: 0, lat: 1, dat: 32'h1234_5678});
    push(1'b0, 32'h3000_0010, 32'h0, 4'hF, acc);
    push(1'b0, 32'h3000_0014, 32'h0, 4'hF, acc);
    wait_rsp(2, "tmo_rsp_count");
    chk("tmo_stb_len", stb_len_at(0), 8);
    chk("tmo_err", rsp_at(0).err, 1);
    chk("tmo_dat", rsp_at(0).dat, 32'hBAD1_BAD1);
    chk("tmo_next_err", rsp_at(1).err, 0);
    chk("tmo_next_dat", rsp_at(1).dat, 32'h1234_5678);
    repeat (2) @(negedge clk);

    // Reset mid-transaction with two requests queued.
    for (int i = 0; i < 3; i++) s_plan.push_back('{kind: 3, lat: 0, dat: 32'h0});
    for (int i = 0; i < 3; i++) push(1'b0, 32'h5000_0000 + 32'(i * 4), 32'h0, 4'hF, acc);
    @(negedge clk);
    chk("rst_pre_stb", stb_o, 1);
    #2 nrst = 0;
    #1;
    chk("rst_async_stb", stb_o, 0);
    chk("rst_async_cyc", cyc_o, 0);
    chk("rst_async_adr", adr_o, 0);
    chk("rst_async_ready", req_ready, 1);
    chk("rst_async_busy", busy, 0);
    s_plan.delete();
    repeat (2) @(negedge clk);
    clear_logs();
    nrst = 1;
    repeat (20) @(negedge clk);
    chk("rst_no_rsp", rsp_log.size(), 0);
    chk("rst_idle_busy", busy, 0);

    // 64-bit data path: byte selects and error pattern at full width.
    x_valid = 1; x_adr_i = 32'h4000_0000; x_sel_i = 8'hA5;
    @(negedge clk);
    x_valid = 0;
    n = 0;
    while (!x_stb && n < 50) begin @(negedge clk); n++; end
    chk("w64_stb", x_stb, 1);
    chk("w64_sel", x_sel, 8'hA5);
    x_err = 1;
    n = 0;
    while (!x_rsp_vld && n < 50) begin @(negedge clk); n++; end
    x_err = 0;
    chk("w64_rsp_vld", x_rsp_vld, 1);
    chk("w64_rsp_err", x_rsp_err, 1);
    chk("w64_rsp_dat", x_rsp_dat, 64'hBAD1_BAD1_BAD1_BAD1);
    @(negedge clk);
    chk("w64_cyc_low", x_cyc, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
